// File: rtl/izz_pkg.sv
// Shared definitions for the inverse-zigzag controller: defaults, FSM state
// encoding, the row-to-select mapping and the zigzag position of a raster cell.
package izz_pkg;

    localparam int IZZ_DW_DEF       = 8;
    localparam int IZZ_ROW_BASE_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } izz_state_e;

    // Datapath select code for a raster row; the 3-bit add wraps modulo 8.
    function automatic logic [2:0] row_to_sel(input logic [2:0] row, input int row_base);
        logic [2:0] base_s;
        base_s = 3'(row_base % 8);
        return row + base_s;
    endfunction

    // Zigzag scan position of raster cell (r, c) in an 8x8 block.
    // Even anti-diagonals run bottom-left to top-right, odd ones the other way.
    function automatic int zz_pos(input int r, input int c);
        int diag_s;
        int base_s;
        int off_s;
        diag_s = r + c;
        if (diag_s < 8) begin
            base_s = (diag_s * (diag_s + 1)) / 2;
            off_s  = ((diag_s % 2) == 0) ? c : r;
        end else begin
            base_s = 64 - ((15 - diag_s) * (16 - diag_s)) / 2;
            off_s  = ((diag_s % 2) == 0) ? (7 - r) : (r - (diag_s - 7));
        end
        return base_s + off_s;
    endfunction

endpackage

// File: rtl/inverse_zigzag.sv
// Inverse-zigzag datapath: reorders a zigzag block into raster order and
// returns the row addressed by the select code (row = sel - ROW_BASE mod 8).
module inverse_zigzag
    import izz_pkg::*;
#(
    parameter int DW       = IZZ_DW_DEF,
    parameter int ROW_BASE = IZZ_ROW_BASE_DEF
) (
    input  logic [64*DW-1:0] blk,
    input  logic [2:0]       zz_sel,
    output logic [8*DW-1:0]  row_data
);

    localparam logic [2:0] BASE3 = 3'(ROW_BASE % 8);

    logic [64*DW-1:0] raster_s;
    logic [8*DW-1:0]  rows_s [8];
    logic [2:0]       row_idx_s;

    for (genvar r = 0; r < 8; r++) begin : g_row
        for (genvar c = 0; c < 8; c++) begin : g_col
            localparam int K = zz_pos(r, c);
            assign raster_s[(63 - (r * 8 + c)) * DW +: DW] = blk[(63 - K) * DW +: DW];
        end
        assign rows_s[r] = raster_s[(7 - r) * 8 * DW +: 8 * DW];
    end

    assign row_idx_s = zz_sel - BASE3;

    // Row selection driven by the select code.
    always_comb begin
        row_data = rows_s[row_idx_s];
    end

endmodule

// File: rtl/inverse_zigzag_ctrl.sv
// Inverse-zigzag block controller: accepts 64-coefficient zigzag blocks and
// emits 8 raster rows each. Define IZZ_DBLBUF_EN for a ping-pong holding buffer.
module inverse_zigzag_ctrl
    import izz_pkg::*;
#(
    parameter int DW       = IZZ_DW_DEF,
    parameter int ROW_BASE = IZZ_ROW_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [64*DW-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*DW-1:0]   out_data,
    output logic [2:0]        out_row,
    output logic              out_last,
    output logic [2:0]        zz_sel,
    output logic [15:0]       blk_done
);

    izz_state_e       state_r;
    izz_state_e       state_nxt_s;
    logic [2:0]       row_r;
    logic [15:0]      blk_done_r;
    logic             emit_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             last_xfer_s;
    logic             pending_s;
    logic             ready_raw_s;
    logic [64*DW-1:0] active_blk_s;

    assign emit_s      = !rst && (state_r == EMIT);
    assign in_xfer_s   = in_valid && in_ready;
    assign out_xfer_s  = emit_s && out_ready;
    assign last_xfer_s = out_xfer_s && (row_r == 3'd7);

`ifdef IZZ_DBLBUF_EN
    logic [64*DW-1:0] buf_r [2];
    logic [1:0]       full_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;

    // A buffer being freed by the row-7 transfer can be refilled in the same cycle.
    assign ready_raw_s  = !(&full_r) || last_xfer_s;
    assign pending_s    = full_r[~rd_ptr_r];
    assign active_blk_s = buf_r[rd_ptr_r];

    // Buffer occupancy and ping-pong pointers; set after clear so a same-cycle refill wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r   <= 2'b00;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            if (last_xfer_s) begin
                full_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r         <= ~rd_ptr_r;
            end
            if (in_xfer_s) begin
                full_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r         <= ~wr_ptr_r;
            end
        end
    end

    // Holding-register capture on input transfer.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            buf_r[wr_ptr_r] <= in_data;
        end
    end
`else
    logic [64*DW-1:0] hold_r;

    assign ready_raw_s  = (state_r == IDLE);
    assign pending_s    = 1'b0;
    assign active_blk_s = hold_r;

    // Holding-register capture on input transfer.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            hold_r <= in_data;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_xfer_s) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EMIT: begin
                if (last_xfer_s) begin
                    state_nxt_s = (pending_s || in_xfer_s) ? EMIT : IDLE;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs; everything is forced to its reset value while rst is high.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_row   = 3'd0;
        out_last  = 1'b0;
        blk_done  = 16'h0000;
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end else begin
            in_ready  = ready_raw_s;
            out_valid = emit_s;
            out_row   = row_r;
            out_last  = emit_s && (row_r == 3'd7);
            blk_done  = blk_done_r;
        end
    end

    // Row counter and completed-block counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r      <= 3'd0;
            blk_done_r <= 16'h0000;
        end else if (last_xfer_s) begin
            row_r      <= 3'd0;
            blk_done_r <= blk_done_r + 16'd1;
        end else if (out_xfer_s) begin
            row_r      <= row_r + 3'd1;
        end else begin
            row_r      <= row_r;
        end
    end

    assign zz_sel = row_to_sel(out_row, ROW_BASE);

    inverse_zigzag #(
        .DW       (DW),
        .ROW_BASE (ROW_BASE)
    ) u_datapath (
        .blk      (active_blk_s),
        .zz_sel   (zz_sel),
        .row_data (out_data)
    );

endmodule

// File: tb/tb_inverse_zigzag_ctrl.sv
// Directed self-checking bench for inverse_zigzag_ctrl (DW = 8, ROW_BASE = 2).
// Expectations follow IZZ_DBLBUF_EN when it is defined for the build.
module tb_inverse_zigzag_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [2:0]   out_row;
    logic         out_last;
    logic [2:0]   zz_sel;
    logic [15:0]  blk_done;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_done;

    // Raster cell -> zigzag position, written out by hand from the JPEG scan.
    int zz_tab [64] = '{ 0,  1,  5,  6, 14, 15, 27, 28,
                         2,  4,  7, 13, 16, 26, 29, 42,
                         3,  8, 12, 17, 25, 30, 41, 43,
                         9, 11, 18, 24, 31, 40, 44, 53,
                        10, 19, 23, 32, 39, 45, 52, 54,
                        20, 22, 33, 38, 46, 51, 55, 60,
                        21, 34, 37, 47, 50, 56, 59, 61,
                        35, 36, 48, 49, 57, 58, 62, 63};
    int sel_tab [8] = '{2, 3, 4, 5, 6, 7, 0, 1};

`ifdef IZZ_DBLBUF_EN
    localparam int SPAN = 32;
`else
    localparam int SPAN = 35;
`endif

    inverse_zigzag_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .zz_sel    (zz_sel),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] make_blk(input int base);
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[(63 - k) * 8 +: 8] = 8'(k + base);
        return b;
    endfunction

    function automatic logic [63:0] exp_row(input int r, input int base);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[(7 - c) * 8 +: 8] = 8'(zz_tab[r * 8 + c] + base);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, then follow its rows, optionally stalling or stopping early.
    task automatic send_and_drain(input int base, input int stall_row, input int stall_len,
                                  input int abort_row, output logic [63:0] r0, output logic [63:0] r7);
        bit   got;
        int   er;
        int   sc;
        logic rdy;
        r0 = '0;
        r7 = '0;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = make_blk(base);
        out_ready = 1'b1;
        for (int w = 0; w < 20 && !got; w++) begin
            #4;
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready got 0 want 1 within 20 cycles");
            return;
        end
        er = 0;
        sc = 0;
        for (int cyc = 0; cyc < 40 && er < 8; cyc++) begin
            rdy = !(er == stall_row && sc < stall_len);
            out_ready = rdy;
            #4;
            if (er == 0) r0 = out_data;
            if (er == 7) r7 = out_data;
            n_cmp++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL row_valid r%0d: got %b want 1", er, out_valid); end
            n_cmp++;
            if (out_row !== 3'(er)) begin n_err++; $display("FAIL row_index: got %0d want %0d", out_row, er); end
            n_cmp++;
            if (zz_sel !== 3'(sel_tab[er])) begin n_err++; $display("FAIL zz_sel r%0d: got %0d want %0d", er, zz_sel, sel_tab[er]); end
            n_cmp++;
            if (out_data !== exp_row(er, base)) begin n_err++; $display("FAIL row_data r%0d: got %h want %h", er, out_data, exp_row(er, base)); end
            n_cmp++;
            if (out_last !== (er == 7)) begin n_err++; $display("FAIL out_last r%0d: got %b want %b", er, out_last, (er == 7)); end
            if (er == abort_row) return;
            tick();
            if (rdy) er++;
            else sc++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (er != 8) begin n_err++; $display("FAIL row_timeout: got %0d rows want 8", er); end
        exp_done = exp_done + 16'd1;
        #4;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL end_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (blk_done !== exp_done) begin n_err++; $display("FAIL blk_done: got %h want %h", blk_done, exp_done); end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #4;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL rst_valid_last: got %b%b want 00", out_valid, out_last); end
        n_cmp++;
        if (out_row !== 3'd0 || zz_sel !== 3'd2) begin n_err++; $display("FAIL rst_row_sel: got %0d/%0d want 0/2", out_row, zz_sel); end
        n_cmp++;
        if (blk_done !== 16'h0000) begin n_err++; $display("FAIL rst_blk_done: got %h want 0000", blk_done); end
        tick();
        rst = 1'b0;
        #4;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
        tick();
        exp_done = 16'h0000;
    endtask

    task automatic test_single_block();
        logic [63:0] r0;
        logic [63:0] r7;
        send_and_drain(0, -1, 0, -1, r0, r7);
        n_cmp++;
        if (r0 !== 64'h0001_0506_0E0F_1B1C) begin n_err++; $display("FAIL single_row0: got %h want 000105060e0f1b1c", r0); end
        n_cmp++;
        if (r7 !== 64'h2324_3031_393A_3E3F) begin n_err++; $display("FAIL single_row7: got %h want 23243031393a3e3f", r7); end
    endtask

    task automatic test_stall();
        logic [63:0] r0;
        logic [63:0] r7;
        send_and_drain(8'h40, 2, 3, -1, r0, r7);
    endtask

    task automatic test_back_to_back();
        int   sent;
        int   rblk;
        int   rrow;
        int   first_c;
        int   last_c;
        int   vcnt;
        logic acc;
        logic ov;
        sent = 0; rblk = 0; rrow = 0; first_c = -1; last_c = -1; vcnt = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && rblk < 4; c++) begin
            in_valid = (sent < 4);
            in_data  = make_blk(32 * sent + 1);
            #4;
            ov  = out_valid;
            acc = in_valid && in_ready;
            if (ov) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                vcnt++;
                n_cmp++;
                if (out_row !== 3'(rrow) || out_data !== exp_row(rrow, 32 * rblk + 1)) begin
                    n_err++;
                    $display("FAIL b2b_row blk%0d: got row %0d data %h want row %0d data %h",
                             rblk, out_row, out_data, rrow, exp_row(rrow, 32 * rblk + 1));
                end
`ifndef IZZ_DBLBUF_EN
                n_cmp++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_in_emit: got %b want 0", in_ready); end
`endif
            end
            tick();
            if (acc) sent++;
            if (ov) begin
                if (rrow == 7) begin rrow = 0; rblk++; end
                else rrow++;
            end
        end
        in_valid = 1'b0;
        exp_done = exp_done + 16'd4;
        #4;
        n_cmp++;
        if (rblk != 4 || vcnt != 32) begin n_err++; $display("FAIL b2b_count: got %0d blocks %0d rows want 4/32", rblk, vcnt); end
        n_cmp++;
        if (last_c - first_c + 1 != SPAN) begin n_err++; $display("FAIL b2b_span: got %0d cycles want %0d", last_c - first_c + 1, SPAN); end
        n_cmp++;
        if (blk_done !== exp_done) begin n_err++; $display("FAIL b2b_blk_done: got %h want %h", blk_done, exp_done); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [63:0] r0;
        logic [63:0] r7;
        send_and_drain(8'h80, -1, 0, 4, r0, r7);
        tick();
        rst = 1'b1;
        #4;
        n_cmp++;
        if (out_valid !== 1'b0 || blk_done !== 16'h0000) begin n_err++; $display("FAIL mid_rst: got valid %b done %h want 0/0000", out_valid, blk_done); end
        tick();
        rst = 1'b0;
        #4;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL after_rst: got valid %b ready %b want 0/1", out_valid, in_ready); end
        tick();
        exp_done = 16'h0000;
        send_and_drain(8'h90, -1, 0, -1, r0, r7);
    endtask

    task automatic test_wrap();
        logic [63:0] r0;
        logic [63:0] r7;
        force dut.blk_done_r = 16'hFFFF;
        tick();
        release dut.blk_done_r;
        #4;
        n_cmp++;
        if (blk_done !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", blk_done); end
        tick();
        exp_done = 16'hFFFF;
        send_and_drain(8'h0C, -1, 0, -1, r0, r7);
        n_cmp++;
        if (blk_done !== 16'h0000) begin n_err++; $display("FAIL wrap_value: got %h want 0000", blk_done); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_done = 16'h0000;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_single_block();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
